step_pulse_meter: RTL and testbench

- Receive-side monitor for the stepper-motor step interface.
- Samples a step pulse train, such as the one produced by the SM step generator, plus a direction line.
- Measures step period and high-pulse width in clk cycles and tracks signed motor position.
- Flags a stalled motor when steps stop arriving; used for closed-loop checking of SM drive.

---
 rtl/step_pulse_meter_if.sv | 25 ++
 rtl/step_pulse_meter.sv | 137 +++++++++++++
 tb/tb_step_pulse_meter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_pulse_meter_if.sv
// Signal bundle between a step/direction source and the step pulse meter.
// The master drives the raw step/dir lines and the clear strobe; the meter answers with its measurements.
interface step_pulse_meter_if #(
    parameter int SIZE  = 16,
    parameter int POS_W = 24
);
    logic             step_in;
    logic             dir_in;
    logic             clr_pos;
    logic [SIZE-1:0]  period;
    logic [SIZE-1:0]  width;
    logic             period_valid;
    logic [POS_W-1:0] position;
    logic             stalled;

    modport master (
        output step_in, dir_in, clr_pos,
        input  period, width, period_valid, position, stalled
    );

    modport slave (
        input  step_in, dir_in, clr_pos,
        output period, width, period_valid, position, stalled
    );
endinterface

// File: rtl/step_pulse_meter.sv
// Receive-side step/direction monitor: measures step period and pulse width,
// tracks signed motor position and flags a stall when steps stop arriving.
module step_pulse_meter #(
    parameter int SIZE    = 16,
    parameter int POS_W   = 24,
    parameter int TIMEOUT = 50000
) (
    input  logic                clk,
    input  logic                rst,
    step_pulse_meter_if.slave   bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SIZE-1:0]  CNT_ONE   = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [SIZE-1:0]  CNT_MAX   = {SIZE{1'b1}};
    localparam logic [SIZE-1:0]  TIMEOUT_C = SIZE'(TIMEOUT);
    localparam logic [POS_W-1:0] POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       step_sync_q, step_sync_d;
    logic [1:0]       dir_sync_q, dir_sync_d;
    logic [SIZE-1:0]  cnt_q, cnt_d;
    logic [SIZE-1:0]  hcnt_q, hcnt_d;
    logic [SIZE-1:0]  period_q, period_d;
    logic [SIZE-1:0]  width_q, width_d;
    logic             period_valid_q, period_valid_d;
    logic             stalled_q, stalled_d;
    logic [POS_W-1:0] position_q, position_d;
    logic             rise_s, fall_s, dir_s;

    // Synchronizer shift and edge detection on the second/third stages
    always_comb begin
        step_sync_d = {step_sync_q[1:0], bus.step_in};
        dir_sync_d  = {dir_sync_q[0], bus.dir_in};
        rise_s      = step_sync_q[1] & ~step_sync_q[2];
        fall_s      = ~step_sync_q[1] & step_sync_q[2];
        dir_s       = dir_sync_q[1];
    end

    // Period / stall state machine; a rise always beats the timeout
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        stalled_d      = stalled_q;
        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    cnt_d     = CNT_ONE;
                    stalled_d = 1'b0;
                    state_d   = RUN;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            RUN: begin
                if (rise_s) begin
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    cnt_d          = CNT_ONE;
                end else if (cnt_q == TIMEOUT_C) begin
                    stalled_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // High-time counter (saturating) and width capture on the falling edge
    always_comb begin
        if (rise_s) begin
            hcnt_d = CNT_ONE;
        end else if (step_sync_q[1] && (hcnt_q != CNT_MAX)) begin
            hcnt_d = hcnt_q + CNT_ONE;
        end else begin
            hcnt_d = hcnt_q;
        end
        if (fall_s) begin
            width_d = hcnt_q;
        end else begin
            width_d = width_q;
        end
    end

    // Position tracking; a coincident clear swallows the step
    always_comb begin
        if (bus.clr_pos) begin
            position_d = {POS_W{1'b0}};
        end else if (rise_s) begin
            position_d = dir_s ? (position_q + POS_ONE) : (position_q - POS_ONE);
        end else begin
            position_d = position_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            step_sync_q    <= 3'b000;
            dir_sync_q     <= 2'b00;
            cnt_q          <= {SIZE{1'b0}};
            hcnt_q         <= {SIZE{1'b0}};
            period_q       <= {SIZE{1'b0}};
            width_q        <= {SIZE{1'b0}};
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b1;
            position_q     <= {POS_W{1'b0}};
        end else begin
            state_q        <= state_d;
            step_sync_q    <= step_sync_d;
            dir_sync_q     <= dir_sync_d;
            cnt_q          <= cnt_d;
            hcnt_q         <= hcnt_d;
            period_q       <= period_d;
            width_q        <= width_d;
            period_valid_q <= period_valid_d;
            stalled_q      <= stalled_d;
            position_q     <= position_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.width        = width_q;
    assign bus.period_valid = period_valid_q;
    assign bus.position     = position_q;
    assign bus.stalled      = stalled_q;
endmodule

// File: tb/tb_step_pulse_meter.sv
// Self-checking bench for step_pulse_meter: table-driven pulse trains, hand-written
// stall/clear/wrap sequences and a randomized run against an event-level reference model.
module tb_step_pulse_meter;
    localparam int TIMEOUT = 100;

    logic clk;
    logic rst;
    logic step_in;
    logic dir_in;
    logic clr_pos;

    step_pulse_meter_if #(.SIZE(16), .POS_W(24)) m_if ();
    step_pulse_meter_if #(.SIZE(16), .POS_W(4))  w_if ();

    assign m_if.step_in = step_in;
    assign m_if.dir_in  = dir_in;
    assign m_if.clr_pos = clr_pos;
    assign w_if.step_in = step_in;
    assign w_if.dir_in  = dir_in;
    assign w_if.clr_pos = clr_pos;

    step_pulse_meter #(.SIZE(16), .POS_W(24), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m_if)
    );

    step_pulse_meter #(.SIZE(16), .POS_W(4), .TIMEOUT(TIMEOUT)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (w_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int pv_seen = 0;

    // Reference model: raw sample history plus event timestamps
    logic [2:0]  m_sy;
    logic [1:0]  m_dy;
    int          cyc = 0;
    int          m_last_rise = 0;
    int          m_high_start = 0;
    bit          m_ref = 1'b0;
    logic [15:0] m_period;
    logic [15:0] m_width;
    logic        m_pv;
    logic        m_stalled;
    logic [23:0] m_pos;
    logic [3:0]  m_pos4;

    typedef struct {
        int          hi;
        int          lo;
        int          n;
        bit          dir;
        bit          rst_first;
        int          exp_period;
        int          exp_width;
        logic [23:0] exp_pos;
        int          exp_pv;
    } row_t;

    row_t rows[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic rise;
        logic fall;
        int   gap;
        int   hw;
        if (rst) begin
            m_sy      = 3'b000;
            m_dy      = 2'b00;
            m_period  = 16'd0;
            m_width   = 16'd0;
            m_pv      = 1'b0;
            m_stalled = 1'b1;
            m_pos     = 24'd0;
            m_pos4    = 4'd0;
            m_ref     = 1'b0;
        end else begin
            rise = m_sy[1] & ~m_sy[2];
            fall = ~m_sy[1] & m_sy[2];
            gap  = cyc - m_last_rise;
            m_pv = 1'b0;
            if (rise) begin
                if (m_ref) begin
                    m_period = 16'(gap);
                    m_pv     = 1'b1;
                end
                m_ref       = 1'b1;
                m_stalled   = 1'b0;
                m_last_rise = cyc;
            end else if (m_ref && (gap == TIMEOUT)) begin
                m_stalled = 1'b1;
                m_ref     = 1'b0;
            end
            if (rise) begin
                m_high_start = cyc;
            end else if (fall) begin
                hw      = cyc - m_high_start;
                m_width = (hw > 65535) ? 16'hFFFF : 16'(hw);
            end
            if (clr_pos) begin
                m_pos  = 24'd0;
                m_pos4 = 4'd0;
            end else if (rise) begin
                m_pos  = m_dy[1] ? m_pos + 24'd1 : m_pos - 24'd1;
                m_pos4 = m_dy[1] ? m_pos4 + 4'd1 : m_pos4 - 4'd1;
            end
            m_sy = {m_sy[1:0], step_in};
            m_dy = {m_dy[0], dir_in};
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("period",        32'(m_if.period),       32'(m_period));
        chk("width",         32'(m_if.width),        32'(m_width));
        chk("period_valid",  32'(m_if.period_valid), 32'(m_pv));
        chk("position",      32'(m_if.position),     32'(m_pos));
        chk("stalled",       32'(m_if.stalled),      32'(m_stalled));
        chk("wrap_position", 32'(w_if.position),     32'(m_pos4));
        if (m_if.period_valid) pv_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse(input int hi, input int lo);
        step_in = 1'b1;
        repeat (hi) tick();
        step_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_reset();
        step_in = 1'b0;
        clr_pos = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic rnd_tick();
        clr_pos = ($urandom_range(0, 24) == 0);
        rst     = ($urandom_range(0, 399) == 0);
        tick();
        clr_pos = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        int wait_n;
        int hi;
        int lo;

        rows[0] = '{hi: 3, lo: 7,  n: 5, dir: 1'b1, rst_first: 1'b1, exp_period: 10, exp_width: 3, exp_pos: 24'd5,       exp_pv: 4};
        rows[1] = '{hi: 4, lo: 8,  n: 4, dir: 1'b1, rst_first: 1'b1, exp_period: 12, exp_width: 4, exp_pos: 24'd4,       exp_pv: 3};
        rows[2] = '{hi: 6, lo: 6,  n: 6, dir: 1'b0, rst_first: 1'b0, exp_period: 12, exp_width: 6, exp_pos: 24'hFFFFFE, exp_pv: 6};
        rows[3] = '{hi: 1, lo: 2,  n: 8, dir: 1'b1, rst_first: 1'b0, exp_period: 3,  exp_width: 1, exp_pos: 24'd6,       exp_pv: 8};
        rows[4] = '{hi: 2, lo: 18, n: 3, dir: 1'b0, rst_first: 1'b0, exp_period: 20, exp_width: 2, exp_pos: 24'd3,       exp_pv: 3};

        // Reset with step_in toggling underneath
        rst     = 1'b1;
        step_in = 1'b0;
        dir_in  = 1'b1;
        clr_pos = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step_in = ~step_in;
            tick();
            chk("rst_period",   32'(m_if.period),       32'd0);
            chk("rst_width",    32'(m_if.width),        32'd0);
            chk("rst_position", 32'(m_if.position),     32'd0);
            chk("rst_stalled",  32'(m_if.stalled),      32'd1);
            chk("rst_pv",       32'(m_if.period_valid), 32'd0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_pv",      32'(m_if.period_valid), 32'd0);
        chk("post_rst_stalled", 32'(m_if.stalled),      32'd1);

        // Table-driven pulse trains
        for (int r = 0; r < 5; r++) begin
            if (rows[r].rst_first) do_reset();
            dir_in  = rows[r].dir;
            pv_seen = 0;
            for (int p = 0; p < rows[r].n; p++) pulse(rows[r].hi, rows[r].lo);
            chk($sformatf("row%0d_period", r),   32'(m_if.period),   32'(rows[r].exp_period));
            chk($sformatf("row%0d_width", r),    32'(m_if.width),    32'(rows[r].exp_width));
            chk($sformatf("row%0d_position", r), 32'(m_if.position), 32'(rows[r].exp_pos));
            chk($sformatf("row%0d_strobes", r),  32'(pv_seen),       32'(rows[r].exp_pv));
            chk($sformatf("row%0d_stalled", r),  32'(m_if.stalled),  32'd0);
        end

        // Stall exactly TIMEOUT cycles after the last detected rise, then recovery
        do_reset();
        dir_in = 1'b1;
        repeat (3) pulse(5, 15);
        wait_n = (m_last_rise + TIMEOUT) - cyc;
        repeat (wait_n) tick();
        chk("stall_before_timeout", 32'(m_if.stalled), 32'd0);
        tick();
        chk("stall_at_timeout", 32'(m_if.stalled), 32'd1);
        repeat (20) tick();
        pv_seen = 0;
        pulse(5, 25);
        chk("recover_stalled", 32'(m_if.stalled), 32'd0);
        chk("recover_no_pv",   32'(pv_seen),      32'd0);
        chk("recover_period",  32'(m_if.period),  32'd20);
        pulse(5, 25);
        chk("recover_period30", 32'(m_if.period), 32'd30);
        chk("recover_pv",       32'(pv_seen),     32'd1);

        // Clear coinciding with a detected rise
        do_reset();
        dir_in = 1'b1;
        repeat (7) pulse(3, 7);
        chk("pre_clear_position", 32'(m_if.position), 32'd7);
        step_in = 1'b1;
        tick();
        tick();
        clr_pos = 1'b1;
        tick();
        clr_pos = 1'b0;
        step_in = 1'b0;
        chk("clear_collision", 32'(m_if.position), 32'd0);
        repeat (7) tick();
        pulse(3, 7);
        chk("after_clear_step", 32'(m_if.position), 32'd1);

        // Four-bit position wrap
        do_reset();
        dir_in = 1'b1;
        repeat (7) pulse(3, 7);
        chk("wrap_pre",     32'(w_if.position), 32'h7);
        pulse(3, 7);
        chk("wrap_forward", 32'(w_if.position), 32'h8);
        dir_in = 1'b0;
        pulse(3, 7);
        chk("wrap_reverse", 32'(w_if.position), 32'h7);

        // Randomized pulse trains with random clears, resets and long gaps
        do_reset();
        for (int i = 0; i < 250; i++) begin
            dir_in = 1'($urandom_range(0, 1));
            hi = $urandom_range(1, 6);
            lo = ($urandom_range(0, 15) == 0) ? 120 : $urandom_range(1, 25);
            step_in = 1'b1;
            repeat (hi) rnd_tick();
            step_in = 1'b0;
            repeat (lo) rnd_tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
